realvalue2dacvolt: RTL and testbench
====================================

Name: realvalue2dacvolt

Overview:
- Reverse path of the ADC scaling chain: takes real-unit setpoints (integer amps for board current, integer volts for gap voltage), scales them back to sensor-domain volts ×1024, and converts them to 16-bit offset-binary DAC codes.
- Serialises the codes as two SPI write frames (channel A = current, channel B = voltage) to a dual-channel DAC.
- Sits between the control loop and the reference DAC pins.

Parameters:
- CUR_GAIN, 5243, round(1024/50·2^8); A → V×1024 reciprocal for the 50 A/V sensor.
- VOLT_GAIN, 524, round(1024/500·2^8); V → V×1024 reciprocal for the 500 V/V sensor.
- GAIN_SHIFT, 8, right arithmetic shift after the gain multiply.
- CODE_SHIFT, 3, left shift from V×1024 to DAC LSBs (1 LSB = 1/8192 V, full scale ±4 V).
- SCLK_DIV, 2, ad_clk cycles per SCLK half-period (≥1).
- CS_GAP, 4, minimum ad_clk cycles cs_n stays high between frames (≥1).
- DAC_CMD, 4'b0011, command nibble "write and update".

Ports:
- ad_clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- set_current  in  16 signed  target current, integer A.
- set_voltage  in  16 signed  target gap voltage, integer V.
- set_valid  in  1  setpoint pair valid.
- set_ready  out  1  block idle, can accept a pair.
- dac_sclk  out  1  SPI clock, idles low.
- dac_cs_n  out  1  SPI chip select, active low.
- dac_sdi  out  1  SPI data, MSB first.
- done  out  1  one-cycle pulse when the channel B frame completes.

Behaviour:
- Clocking and reset: one clock, ad_clk. Reset is synchronous and active-low on rst_n.
- Reset values: set_ready=1, dac_sclk=0, dac_cs_n=1, dac_sdi=0, done=0. The state machine returns to IDLE.
- Reset mid-frame: cs_n rises on the next edge and the frame is abandoned. No partial recovery is attempted.
- Handshake: a transfer occurs on a cycle with set_valid && set_ready.
  - Both inputs are latched on that cycle, and set_ready drops the next cycle.
  - set_valid while busy is ignored; nothing is queued.
- Arithmetic, per channel, pipelined over 2 cycles (CALC1, CALC2):
  - CALC1: prod = in × GAIN, 32-bit signed.
  - CALC2: q10 = prod >>> GAIN_SHIFT (floor). Then c = q10 <<< CODE_SHIFT, saturated to [-32768, 32767]. Then code = c ^ 16'h8000.
  - Saturation is checked on the full 32-bit value, never on a truncated one.
- Frame format, 24 bits MSB first: DAC_CMD[3:0], addr[3:0] (0 = A, 1 = B), code[15:0].
- SPI timing:
  - cs_n falls in the same cycle the first bit (MSB) is driven.
  - sclk rises after SCLK_DIV cycles and falls after another SCLK_DIV. The next bit is driven on that falling edge.
  - After the 24th falling edge, cs_n rises SCLK_DIV cycles later, with sclk low.
  - sdi returns to 0 while cs_n is high.
- States: IDLE → CALC1 → CALC2 → SHIFT_A → GAP → SHIFT_B → DONE → IDLE.
  - GAP holds cs_n high for CS_GAP cycles.
  - DONE lasts one cycle, with done=1. set_ready=1 in the following (IDLE) cycle.
- Latency: accept at cycle 0, cs_n low at cycle 3.
  - One frame lasts 24·2·SCLK_DIV + SCLK_DIV cycles.
  - Total accept → done: 3 + 2·frame + CS_GAP cycles.
- Back-to-back: set_valid held high is accepted again in the first IDLE cycle after done.

Decomposition:
- Shared package (dac_pkg): DAC_CMD, channel addresses, frame width (24), offset-binary XOR constant, gain/shift defaults.
  - The ADC-side constants (50 A/V, 500 V/V) live in the same package so both directions share one source.
- Sub-module dac_spi_tx: a 24-bit shift register with a SCLK_DIV divider, plus start/busy/done.
  - The top instantiates it once and sequences frames A then B.

Test Plan:
- Reset defaults: rst_n=0 for 3 cycles with set_valid=1 → set_ready=1, cs_n=1, sclk=0, sdi=0, done=0, and no accept.
- Positive values: current=10, voltage=60 → frame A = 0x30_8660, frame B = 0x31_83D0.
  - sdi is sampled on sclk rising edges; 24 sclk pulses per frame.
- Negative floor: current=-10 → q10=-205, code 0x7998. Voltage=0 → code 0x8000.
- Saturation: current=200 → 0xFFFF; current=-200 → 0x0000; voltage=32767 → 0xFFFF.
- Timing, SCLK_DIV=2, CS_GAP=4:
  - cs_n low exactly 3 cycles after accept.
  - Frame is 98 cycles, gap is 4 cycles.
  - done comes 203 cycles after accept; set_ready is 0 throughout and 1 the cycle after done.
- Busy-drop and mid-frame reset:
  - A second set_valid during SHIFT_A is ignored; only one A/B pair is emitted.
  - rst_n=0 at bit 10 of frame A → cs_n=1 the next cycle, no done pulse, and a new accept works normally afterwards.

Source files
------------

// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared constants for the ADC scaling chain and its DAC reverse path
package dac_pkg;

    // Sensor transfer ratios used by both the ADC (forward) and DAC (reverse) paths.
    localparam int ADC_CUR_A_PER_V  = 50;
    localparam int ADC_VOLT_V_PER_V = 500;

    // Reciprocal gains in Q8: round(1024 / ratio * 256).
    localparam int CUR_GAIN_DEF   = 5243;
    localparam int VOLT_GAIN_DEF  = 524;
    localparam int GAIN_SHIFT_DEF = 8;
    localparam int CODE_SHIFT_DEF = 3;

    localparam logic [3:0]  DAC_CMD_WR_UPD = 4'b0011;
    localparam logic [3:0]  ADDR_A         = 4'd0;
    localparam logic [3:0]  ADDR_B         = 4'd1;
    localparam int          FRAME_W        = 24;
    localparam logic [15:0] OB_XOR         = 16'h8000;

    // Scaled product -> offset-binary DAC code. Saturation is applied to the
    // full 32-bit shifted value so large setpoints clamp instead of wrapping.
    function automatic logic [15:0] to_dac_code(input logic signed [31:0] prod,
                                                input int gain_shift,
                                                input int code_shift);
        logic signed [31:0] q10;
        logic signed [31:0] c;
        q10 = prod >>> gain_shift;
        c   = q10 <<< code_shift;
        if (c > 32'sd32767) begin
            c = 32'sd32767;
        end else if (c < -32'sd32768) begin
            c = -32'sd32768;
        end
        return c[15:0] ^ OB_XOR;
    endfunction

endpackage

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - single 24-bit SPI write frame transmitter, MSB first, mode 0
// Ports: clk/rst_n; start+frame load a frame when idle; busy while cs_n is low;
// done is high in the last cs_n-low cycle; sclk/cs_n/sdi drive the DAC.
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               busy,
    output logic               done,
    output logic               sclk,
    output logic               cs_n,
    output logic               sdi
);

    localparam logic [15:0] DIV_LAST  = 16'(SCLK_DIV - 1);
    // 48 half periods carry the bits; half 48 is the cs_n hold tail with sclk low.
    localparam logic [5:0]  HALF_LAST = 6'(2 * FRAME_W);

    logic               active_q, active_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [15:0]        div_q, div_d;
    logic [5:0]         half_q, half_d;
    logic               sclk_q, sclk_d;
    logic               cs_n_q, cs_n_d;
    logic               sdi_q, sdi_d;

    always_comb begin
        active_d = active_q;
        shreg_d  = shreg_q;
        div_d    = div_q;
        half_d   = half_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        sdi_d    = sdi_q;
        if (!active_q) begin
            if (start) begin
                active_d = 1'b1;
                shreg_d  = frame;
                div_d    = '0;
                half_d   = '0;
                sclk_d   = 1'b0;
                cs_n_d   = 1'b0;
                sdi_d    = frame[FRAME_W-1];
            end
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            if (half_q == HALF_LAST) begin
                active_d = 1'b0;
                cs_n_d   = 1'b1;
                sclk_d   = 1'b0;
                sdi_d    = 1'b0;
            end else begin
                half_d = half_q + 6'd1;
                if (!half_q[0]) begin
                    sclk_d = 1'b1;
                end else begin
                    // Falling edge: present the next bit. After the 24th fall the
                    // register is all zeros, so sdi settles low for the tail.
                    sclk_d  = 1'b0;
                    shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                    sdi_d   = shreg_q[FRAME_W-2];
                end
            end
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            shreg_q  <= '0;
            div_q    <= '0;
            half_q   <= '0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            sdi_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            shreg_q  <= shreg_d;
            div_q    <= div_d;
            half_q   <= half_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            sdi_q    <= sdi_d;
        end
    end

    assign busy = active_q;
    assign done = active_q && (div_q == DIV_LAST) && (half_q == HALF_LAST);
    assign sclk = sclk_q;
    assign cs_n = cs_n_q;
    assign sdi  = sdi_q;

endmodule

// File: rtl/realvalue2dacvolt.sv
// rtl/realvalue2dacvolt.sv - real-unit setpoints to dual-channel DAC SPI frames
// Ports: ad_clk/rst_n; set_current/set_voltage with set_valid/set_ready handshake;
// dac_sclk/dac_cs_n/dac_sdi SPI pins; done pulses when the channel B frame ends.
module realvalue2dacvolt
    import dac_pkg::*;
#(
    parameter int         CUR_GAIN   = CUR_GAIN_DEF,
    parameter int         VOLT_GAIN  = VOLT_GAIN_DEF,
    parameter int         GAIN_SHIFT = GAIN_SHIFT_DEF,
    parameter int         CODE_SHIFT = CODE_SHIFT_DEF,
    parameter int         SCLK_DIV   = 2,
    parameter int         CS_GAP     = 4,
    parameter logic [3:0] DAC_CMD    = DAC_CMD_WR_UPD
) (
    input  logic               ad_clk,
    input  logic               rst_n,
    input  logic signed [15:0] set_current,
    input  logic signed [15:0] set_voltage,
    input  logic               set_valid,
    output logic               set_ready,
    output logic               dac_sclk,
    output logic               dac_cs_n,
    output logic               dac_sdi,
    output logic               done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CALC1   = 3'd1;
    localparam logic [2:0] S_CALC2   = 3'd2;
    localparam logic [2:0] S_SHIFT_A = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_SHIFT_B = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic signed [31:0] CUR_GAIN_S  = 32'(CUR_GAIN);
    localparam logic signed [31:0] VOLT_GAIN_S = 32'(VOLT_GAIN);
    localparam logic [15:0]        GAP_LAST    = 16'(CS_GAP - 1);

    logic [2:0]         state_q, state_d;
    logic signed [15:0] cur_q, cur_d;
    logic signed [15:0] volt_q, volt_d;
    logic signed [31:0] prod_cur_q, prod_cur_d;
    logic signed [31:0] prod_volt_q, prod_volt_d;
    logic [15:0]        code_b_q, code_b_d;
    logic [15:0]        gap_cnt_q, gap_cnt_d;

    logic               tx_start;
    logic [FRAME_W-1:0] tx_frame;
    logic               tx_busy;
    logic               tx_done;
    logic [15:0]        code_a;
    logic [15:0]        code_b_calc;
    logic signed [31:0] cur_ext;
    logic signed [31:0] volt_ext;

    assign cur_ext     = {{16{cur_q[15]}}, cur_q};
    assign volt_ext    = {{16{volt_q[15]}}, volt_q};
    assign code_a      = to_dac_code(prod_cur_q, GAIN_SHIFT, CODE_SHIFT);
    assign code_b_calc = to_dac_code(prod_volt_q, GAIN_SHIFT, CODE_SHIFT);

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        volt_d      = volt_q;
        prod_cur_d  = prod_cur_q;
        prod_volt_d = prod_volt_q;
        code_b_d    = code_b_q;
        gap_cnt_d   = gap_cnt_q;
        tx_start    = 1'b0;
        tx_frame    = {DAC_CMD, ADDR_A, code_a};
        case (state_q)
            S_IDLE: begin
                if (set_valid) begin
                    cur_d   = set_current;
                    volt_d  = set_voltage;
                    state_d = S_CALC1;
                end
            end
            S_CALC1: begin
                prod_cur_d  = cur_ext * CUR_GAIN_S;
                prod_volt_d = volt_ext * VOLT_GAIN_S;
                state_d     = S_CALC2;
            end
            S_CALC2: begin
                // Channel A code feeds the transmitter directly; B is held for later.
                code_b_d = code_b_calc;
                tx_start = 1'b1;
                state_d  = S_SHIFT_A;
            end
            S_SHIFT_A: begin
                if (tx_done) begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST && !tx_busy) begin
                    tx_start = 1'b1;
                    tx_frame = {DAC_CMD, ADDR_B, code_b_q};
                    state_d  = S_SHIFT_B;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            S_SHIFT_B: begin
                if (tx_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            volt_q      <= '0;
            prod_cur_q  <= '0;
            prod_volt_q <= '0;
            code_b_q    <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            volt_q      <= volt_d;
            prod_cur_q  <= prod_cur_d;
            prod_volt_q <= prod_volt_d;
            code_b_q    <= code_b_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    dac_spi_tx #(
        .SCLK_DIV (SCLK_DIV)
    ) u_tx (
        .clk   (ad_clk),
        .rst_n (rst_n),
        .start (tx_start),
        .frame (tx_frame),
        .busy  (tx_busy),
        .done  (tx_done),
        .sclk  (dac_sclk),
        .cs_n  (dac_cs_n),
        .sdi   (dac_sdi)
    );

    assign set_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_realvalue2dacvolt.sv
// tb/tb_realvalue2dacvolt.sv - scoreboard bench for realvalue2dacvolt
module tb_realvalue2dacvolt;

    logic               ad_clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] set_current = '0;
    logic signed [15:0] set_voltage = '0;
    logic               set_valid = 1'b0;
    wire                set_ready;
    wire                dac_sclk;
    wire                dac_cs_n;
    wire                dac_sdi;
    wire                done;

    always #5 ad_clk = ~ad_clk;

    realvalue2dacvolt dut (
        .ad_clk      (ad_clk),
        .rst_n       (rst_n),
        .set_current (set_current),
        .set_voltage (set_voltage),
        .set_valid   (set_valid),
        .set_ready   (set_ready),
        .dac_sclk    (dac_sclk),
        .dac_cs_n    (dac_cs_n),
        .dac_sdi     (dac_sdi),
        .done        (done)
    );

    int          checks = 0;
    int          failures = 0;
    logic [23:0] exp_q[$];
    int          done_cnt = 0;
    int          exp_done = 0;
    int          partial_cnt = 0;
    int          nbits = 0;
    logic [23:0] rx_word = '0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    bit          abort_window = 1'b0;

    bit          cs_a[0:205];
    bit          dn_a[0:205];
    bit          rd_a[0:205];
    int          k, s, cnt, d0, waitc, cur, volt;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: floor(v*gain/256)*8, clamped to 16-bit signed, then biased by 32768.
    function automatic logic [15:0] model_code(input int v, input int gain);
        longint p, q, c;
        p = longint'(v) * gain;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        c = q * 8;
        if (c > 32767) c = 32767;
        if (c < -32768) c = -32768;
        return 16'(c + 32768);
    endfunction

    function automatic logic [23:0] mk(input int addr, input int v, input int gain);
        return {4'h3, 4'(addr), model_code(v, gain)};
    endfunction

    // Monitor: rebuild each frame from sdi at sclk rising edges, compare on cs_n rise.
    always @(negedge ad_clk) begin
        if (!dac_cs_n && dac_sclk && !prev_sclk) begin
            rx_word = {rx_word[22:0], dac_sdi};
            nbits++;
        end
        if (dac_cs_n && !prev_cs) begin
            check("sdi_idle", dac_sdi, 0);
            if (abort_window && nbits != 24) begin
                partial_cnt++;
            end else begin
                check("frame_bits", nbits, 24);
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", rx_word, 0);
                end else begin
                    check("frame", rx_word, exp_q.pop_front());
                end
            end
            nbits   = 0;
            rx_word = '0;
        end
        if (done) done_cnt++;
        prev_cs   = dac_cs_n;
        prev_sclk = dac_sclk;
    end

    task automatic wait_ready();
        waitc = 0;
        while (!set_ready && waitc < 2000) begin
            @(negedge ad_clk);
            waitc++;
        end
        check("ready_wait", set_ready, 1);
    endtask

    task automatic issue(input int c, input int v, input logic [23:0] ea, input logic [23:0] eb);
        wait_ready();
        set_current = 16'(c);
        set_voltage = 16'(v);
        set_valid   = 1'b1;
        exp_q.push_back(ea);
        exp_q.push_back(eb);
        exp_done++;
        @(negedge ad_clk);
        set_valid = 1'b0;
    endtask

    task automatic issue_model(input int c, input int v);
        issue(c, v, mk(0, c, 5243), mk(1, v, 524));
    endtask

    function automatic int pick_value();
        int r;
        r = $urandom_range(0, 2);
        if (r == 0) return $urandom_range(0, 400) - 200;
        if (r == 1) return int'($signed(16'($urandom)));
        return ($urandom_range(0, 1) == 1) ? 32767 : -32768;
    endfunction

    initial begin
        // Reset with set_valid asserted: outputs at defaults, nothing accepted.
        rst_n       = 1'b0;
        set_valid   = 1'b1;
        set_current = 16'sd5;
        set_voltage = 16'sd5;
        repeat (3) begin
            @(negedge ad_clk);
            check("rst_ready", set_ready, 1);
            check("rst_cs_n", dac_cs_n, 1);
            check("rst_sclk", dac_sclk, 0);
            check("rst_sdi", dac_sdi, 0);
            check("rst_done", done, 0);
        end
        set_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (3) @(negedge ad_clk);
        check("no_accept_cs", dac_cs_n, 1);
        check("no_accept_ready", set_ready, 1);

        // Positive values with full timing capture.
        issue(10, 60, 24'h308660, 24'h3183D0);
        for (int i = 1; i <= 205; i++) begin
            cs_a[i] = dac_cs_n;
            dn_a[i] = done;
            rd_a[i] = set_ready;
            @(negedge ad_clk);
        end
        k = 1;
        while (k <= 205 && cs_a[k]) k++;
        check("cs_low_latency", k, 3);
        s = k;
        while (k <= 205 && !cs_a[k]) k++;
        check("frame_a_len", k - s, 98);
        s = k;
        while (k <= 205 && cs_a[k]) k++;
        check("gap_len", k - s, 4);
        s = k;
        while (k <= 205 && !cs_a[k]) k++;
        check("frame_b_len", k - s, 98);
        k = 1;
        while (k <= 205 && !dn_a[k]) k++;
        check("done_latency", k, 203);
        cnt = 0;
        for (int i = 1; i <= 205; i++) if (dn_a[i]) cnt++;
        check("done_pulses", cnt, 1);
        cnt = 0;
        for (int i = 1; i <= 203; i++) if (rd_a[i]) cnt++;
        check("ready_while_busy", cnt, 0);
        check("ready_after_done", rd_a[204], 1);

        // Floor of negatives, zero, saturation.
        issue(-10, 0, 24'h307998, 24'h318000);
        issue(200, 32767, 24'h30FFFF, 24'h31FFFF);
        issue(-200, -1, 24'h300000, 24'h317FE8);

        // set_valid during SHIFT_A is dropped.
        issue_model(100, 100);
        waitc = 0;
        while (dac_cs_n && waitc < 20) begin
            @(negedge ad_clk);
            waitc++;
        end
        set_current = 16'sd1;
        set_voltage = 16'sd2;
        set_valid   = 1'b1;
        repeat (20) @(negedge ad_clk);
        set_valid = 1'b0;

        // Back-to-back: held set_valid is re-accepted in the IDLE cycle after done.
        wait_ready();
        set_current = -16'sd1234;
        set_voltage = 16'sd777;
        set_valid   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(0, -1234, 5243));
            exp_q.push_back(mk(1, 777, 524));
        end
        exp_done += 2;
        @(negedge ad_clk);
        waitc = 0;
        while (!done && waitc < 400) begin
            @(negedge ad_clk);
            waitc++;
        end
        check("b2b_done_seen", done, 1);
        @(negedge ad_clk);
        check("b2b_ready", set_ready, 1);
        @(negedge ad_clk);
        check("b2b_accept", set_ready, 0);
        set_valid = 1'b0;

        // Randomized pairs against the reference model.
        for (int i = 0; i < 10; i++) begin
            cur  = pick_value();
            volt = pick_value();
            issue_model(cur, volt);
        end

        // Reset in the middle of frame A.
        issue_model(50, 50);
        waitc = 0;
        while (!(nbits >= 10 && !dac_cs_n) && waitc < 300) begin
            @(negedge ad_clk);
            waitc++;
        end
        abort_window = 1'b1;
        rst_n        = 1'b0;
        @(negedge ad_clk);
        check("abort_cs_high", dac_cs_n, 1);
        check("abort_ready", set_ready, 1);
        rst_n = 1'b1;
        exp_q.delete();
        exp_done--;
        d0 = done_cnt;
        repeat (300) @(negedge ad_clk);
        check("abort_no_done", done_cnt, d0);
        check("abort_partial", partial_cnt, 1);
        check("abort_cs_idle", dac_cs_n, 1);
        abort_window = 1'b0;

        issue_model(-7, 300);
        waitc = 0;
        while ((exp_q.size() != 0 || !set_ready) && waitc < 1000) begin
            @(negedge ad_clk);
            waitc++;
        end
        repeat (3) @(negedge ad_clk);
        check("queue_empty", exp_q.size(), 0);
        check("done_count", done_cnt, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
